// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the dual-motor PWM driver.
// Speed commands are signed 12-bit; duties are 11-bit offsets into the shared timebase.
package mtr_drv_pkg;

  localparam int unsigned PWM_W = 11;

  typedef logic [PWM_W-1:0] duty_t;
  typedef logic signed [11:0] spd_t;

  localparam duty_t DUTY_MID = 11'h400;
  localparam int    SPD_MAX  = 1023;
  localparam int    SPD_MIN  = -1023;

  // Clamp to +/-1023 and re-centre on DUTY_MID; the result spans 1..2047.
  function automatic duty_t spd_to_duty(input spd_t spd);
    spd_t sat;
    if (spd > spd_t'(SPD_MAX)) begin
      sat = spd_t'(SPD_MAX);
    end else if (spd < spd_t'(SPD_MIN)) begin
      sat = spd_t'(SPD_MIN);
    end else begin
      sat = spd;
    end
    return duty_t'(sat[PWM_W-1:0]) + DUTY_MID;
  endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// Command/drive bundle between the balance controller and the motor driver.
// master: command source and PWM observer; slave: the driver itself.
interface mtr_drv_if;
  import mtr_drv_pkg::*;

  spd_t lft_spd;
  spd_t rght_spd;
  logic ovr_i;
  logic PWM1_lft;
  logic PWM2_lft;
  logic PWM1_rght;
  logic PWM2_rght;
  logic PWM_synch;
  logic ovr_i_shtdwn;

  modport master (
    output lft_spd,
    output rght_spd,
    output ovr_i,
    input  PWM1_lft,
    input  PWM2_lft,
    input  PWM1_rght,
    input  PWM2_rght,
    input  PWM_synch,
    input  ovr_i_shtdwn
  );

  modport slave (
    input  lft_spd,
    input  rght_spd,
    input  ovr_i,
    output PWM1_lft,
    output PWM2_lft,
    output PWM1_rght,
    output PWM2_rght,
    output PWM_synch,
    output ovr_i_shtdwn
  );

endinterface

// File: rtl/mtr_drv_pwm_nonovr.sv
// Splits one PWM_sig into a registered, non-overlapping high/low-side pair.
// Every PWM_sig edge forces both sides low for NONOVERLAP clocks.
module pwm_nonovr #(
  parameter int unsigned NONOVERLAP = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic PWM_sig,
  output logic PWM1,
  output logic PWM2,
  output logic hs_rise
);

  localparam int unsigned DT_W = (NONOVERLAP > 1) ? $clog2(NONOVERLAP) : 1;
  // The edge cycle itself is the first dead clock, hence the -1.
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(NONOVERLAP - 1);

  logic            sig_q;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            pwm1_q, pwm1_d;
  logic            pwm2_q, pwm2_d;
  logic            rise_q, rise_d;

  always_comb begin
    dt_d   = dt_q;
    pwm1_d = 1'b0;
    pwm2_d = 1'b0;
    if (PWM_sig != sig_q) begin
      dt_d = DT_LOAD;
    end else if (dt_q != '0) begin
      dt_d = dt_q - 1'b1;
    end else begin
      pwm1_d = PWM_sig;
      pwm2_d = ~PWM_sig;
    end
    rise_d = pwm1_d & ~pwm1_q;
  end

  // Reset clears sig_q so the first active cycle is seen as an edge and reloads dead time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      dt_q   <= DT_LOAD;
      pwm1_q <= 1'b0;
      pwm2_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sig_q  <= PWM_sig;
      dt_q   <= dt_d;
      pwm1_q <= pwm1_d;
      pwm2_q <= pwm2_d;
      rise_q <= rise_d;
    end
  end

  assign PWM1    = pwm1_q;
  assign PWM2    = pwm2_q;
  assign hs_rise = rise_q;

endmodule

// File: rtl/mtr_drv.sv
// Dual H-bridge PWM driver: shared 11-bit timebase, saturated duty latching, dead time,
// and (with OVR_I_SHTDWN_EN defined) blanked over-current shutdown.
module mtr_drv
  import mtr_drv_pkg::*;
#(
  parameter int unsigned NONOVERLAP  = 32,
  parameter int unsigned OVR_I_BLANK = 40,
  parameter int unsigned OVR_I_LIMIT = 8
) (
  input logic       clk,
  input logic       rst_n,
  mtr_drv_if.slave  bus
);

  duty_t cnt_q, cnt_d;
  duty_t duty_lft_q, duty_lft_d;
  duty_t duty_rght_q, duty_rght_d;
  logic  synch_q;
  logic  period_end;
  logic  sig_lft, sig_rght;
  logic  pwm1_lft, pwm2_lft, rise_lft;
  logic  pwm1_rght, pwm2_rght, rise_rght;
  logic  shtdwn;

  assign period_end = (cnt_q == '1);

  // Duties only move at the wrap so each period sees one consistent command.
  always_comb begin
    cnt_d       = cnt_q + 1'b1;
    duty_lft_d  = duty_lft_q;
    duty_rght_d = duty_rght_q;
    if (period_end) begin
      duty_lft_d  = spd_to_duty(bus.lft_spd);
      duty_rght_d = spd_to_duty(bus.rght_spd);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      duty_lft_q  <= DUTY_MID;
      duty_rght_q <= DUTY_MID;
      synch_q     <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      duty_lft_q  <= duty_lft_d;
      duty_rght_q <= duty_rght_d;
      synch_q     <= period_end;
    end
  end

  assign sig_lft  = (cnt_q < duty_lft_q);
  assign sig_rght = (cnt_q < duty_rght_q);

  pwm_nonovr #(
    .NONOVERLAP (NONOVERLAP)
  ) u_nonovr_lft (
    .clk     (clk),
    .rst_n   (rst_n),
    .PWM_sig (sig_lft),
    .PWM1    (pwm1_lft),
    .PWM2    (pwm2_lft),
    .hs_rise (rise_lft)
  );

  pwm_nonovr #(
    .NONOVERLAP (NONOVERLAP)
  ) u_nonovr_rght (
    .clk     (clk),
    .rst_n   (rst_n),
    .PWM_sig (sig_rght),
    .PWM1    (pwm1_rght),
    .PWM2    (pwm2_rght),
    .hs_rise (rise_rght)
  );

`ifdef OVR_I_SHTDWN_EN
  localparam int unsigned BLANK_W = $clog2(OVR_I_BLANK + 2);
  localparam int unsigned FLT_W   = $clog2(OVR_I_LIMIT + 1);
  localparam logic [BLANK_W-1:0] BLANK_SAT = BLANK_W'(OVR_I_BLANK + 1);
  localparam logic [FLT_W-1:0]   FLT_MAX   = FLT_W'(OVR_I_LIMIT);

  logic [BLANK_W-1:0] blank_lft_q, blank_lft_d;
  logic [BLANK_W-1:0] blank_rght_q, blank_rght_d;
  logic [FLT_W-1:0]   flt_cnt_q, flt_cnt_d;
  logic               fault_q, fault_d;
  logic               shtdwn_q, shtdwn_d;
  logic               qual_lft, qual_rght, ovr_qual;

  // The counter is stale in the rise cycle itself, so that cycle is excluded explicitly.
  assign qual_lft  = pwm1_lft & ~rise_lft & (blank_lft_q == BLANK_SAT);
  assign qual_rght = pwm1_rght & ~rise_rght & (blank_rght_q == BLANK_SAT);
  assign ovr_qual  = bus.ovr_i & (qual_lft | qual_rght);

  always_comb begin
    blank_lft_d  = blank_lft_q;
    blank_rght_d = blank_rght_q;
    fault_d      = fault_q | ovr_qual;
    flt_cnt_d    = flt_cnt_q;

    if (rise_lft) begin
      blank_lft_d = BLANK_W'(1);
    end else if (blank_lft_q != BLANK_SAT) begin
      blank_lft_d = blank_lft_q + 1'b1;
    end
    if (rise_rght) begin
      blank_rght_d = BLANK_W'(1);
    end else if (blank_rght_q != BLANK_SAT) begin
      blank_rght_d = blank_rght_q + 1'b1;
    end

    // Evaluated on the edge that raises PWM_synch, so shutdown is visible in that cycle.
    if (period_end) begin
      fault_d = 1'b0;
      if (!fault_q) begin
        flt_cnt_d = '0;
      end else if (flt_cnt_q != FLT_MAX) begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
    shtdwn_d = shtdwn_q | (flt_cnt_d == FLT_MAX);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      blank_lft_q  <= '0;
      blank_rght_q <= '0;
      flt_cnt_q    <= '0;
      fault_q      <= 1'b0;
      shtdwn_q     <= 1'b0;
    end else begin
      blank_lft_q  <= blank_lft_d;
      blank_rght_q <= blank_rght_d;
      flt_cnt_q    <= flt_cnt_d;
      fault_q      <= fault_d;
      shtdwn_q     <= shtdwn_d;
    end
  end

  assign shtdwn = shtdwn_q;
`else
  logic unused_sigs;
  assign unused_sigs = ^{bus.ovr_i, rise_lft, rise_rght, OVR_I_BLANK[0], OVR_I_LIMIT[0]};
  assign shtdwn      = 1'b0;
`endif

  assign bus.PWM1_lft     = pwm1_lft & ~shtdwn;
  assign bus.PWM2_lft     = pwm2_lft & ~shtdwn;
  assign bus.PWM1_rght    = pwm1_rght & ~shtdwn;
  assign bus.PWM2_rght    = pwm2_rght & ~shtdwn;
  assign bus.PWM_synch    = synch_q;
  assign bus.ovr_i_shtdwn = shtdwn;

endmodule

// File: tb/tb_mtr_drv.sv
// Directed bench for mtr_drv: per-period high-time counts, saturation, reset, and
// over-current behaviour for whichever OVR_I_SHTDWN_EN build is compiled.
module tb_mtr_drv;
  import mtr_drv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mtr_drv_if bus_if ();

  mtr_drv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples one 2048-clock window starting at the current negedge; optional command
  // change at chg_idx and ovr_i high over [oa,ob] or [oc,od].
  task automatic run_period(input int chg_idx, input int chg_l, input int chg_r,
                            input int oa, input int ob, input int oc, input int od,
                            output int h1l, output int h2l, output int h1r, output int h2r,
                            output int ovl, output int syn, output int sd);
    h1l = 0; h2l = 0; h1r = 0; h2r = 0; ovl = 0; syn = 0; sd = 0;
    for (int i = 0; i < 2048; i++) begin
      if (i == chg_idx) begin
        bus_if.lft_spd  = spd_t'(chg_l);
        bus_if.rght_spd = spd_t'(chg_r);
      end
      bus_if.ovr_i = ((i >= oa) && (i <= ob)) || ((i >= oc) && (i <= od));
      h1l += int'(bus_if.PWM1_lft);
      h2l += int'(bus_if.PWM2_lft);
      h1r += int'(bus_if.PWM1_rght);
      h2r += int'(bus_if.PWM2_rght);
      ovl += int'((bus_if.PWM1_lft & bus_if.PWM2_lft) | (bus_if.PWM1_rght & bus_if.PWM2_rght));
      syn += int'(bus_if.PWM_synch);
      sd  += int'(bus_if.ovr_i_shtdwn);
      @(negedge clk);
    end
    bus_if.ovr_i = 1'b0;
  endtask

  // Releases reset at the current negedge and returns at the first PWM_synch.
  task automatic release_reset(input string tag);
    int n;
    int early;
    early = 0;
    n     = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      n++;
      early += int'(bus_if.PWM1_lft | bus_if.PWM2_lft | bus_if.PWM1_rght | bus_if.PWM2_rght);
    end
    check({tag, "_deadtime_low"}, early, 0);
    @(negedge clk);
    n++;
    check({tag, "_pwm1_lft_first_high"}, bus_if.PWM1_lft, 1);
    check({tag, "_pwm2_lft_first"}, bus_if.PWM2_lft, 0);
    check({tag, "_pwm1_rght_first_high"}, bus_if.PWM1_rght, 1);
    while (!bus_if.PWM_synch && n < 2100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_first_synch_clk"}, n, 2048);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int h1l, h2l, h1r, h2r, ovl, syn, sd, sd_tot;

    bus_if.lft_spd  = '0;
    bus_if.rght_spd = spd_t'(512);
    bus_if.ovr_i    = 1'b0;
    rst_n           = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pwm1_lft", bus_if.PWM1_lft, 0);
    check("rst_pwm2_lft", bus_if.PWM2_lft, 0);
    check("rst_pwm1_rght", bus_if.PWM1_rght, 0);
    check("rst_pwm2_rght", bus_if.PWM2_rght, 0);
    check("rst_synch", bus_if.PWM_synch, 0);
    check("rst_shtdwn", bus_if.ovr_i_shtdwn, 0);

    release_reset("rst1");

    // Zero left, +512 right
    run_period(-1, 0, 0, -1, -2, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("p1_zero_pwm1_lft", h1l, 992);
    check("p1_zero_pwm2_lft", h2l, 992);
    check("p1_fwd_pwm1_rght", h1r, 1504);
    check("p1_fwd_pwm2_rght", h2r, 480);
    check("p1_overlap", ovl, 0);
    check("p1_synch_pulses", syn, 1);

    // Mid-period change must not disturb the current period
    run_period(1000, -2048, 0, -1, -2, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("p2_midchg_pwm1_rght", h1r, 1504);
    check("p2_midchg_pwm2_rght", h2r, 480);
    check("p2_pwm1_lft", h1l, 992);

    // Left saturated low (duty 1), right now zero
    run_period(500, 2047, 0, -1, -2, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("p3_satlo_pwm1_lft", h1l, 0);
    check("p3_satlo_pwm2_lft", h2l, 2015);
    check("p3_zero_pwm1_rght", h1r, 992);
    check("p3_zero_pwm2_rght", h2r, 992);
    check("p3_overlap", ovl, 0);

    // Left saturated high starts; right goes to -1024 for next period
    run_period(500, 2047, -1024, -1, -2, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("p4_sathi_pwm1_lft", h1l, 2015);
    check("p4_zero_pwm2_rght", h2r, 992);

    run_period(-1, 0, 0, -1, -2, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("p5_sathi_pwm1_lft", h1l, 2015);
    check("p5_sathi_pwm2_lft", h2l, 0);
    check("p5_satlo_pwm1_rght", h1r, 0);
    check("p5_satlo_pwm2_rght", h2r, 2015);
    check("p5_overlap", ovl, 0);

    // Reset mid-period
    repeat (700) @(negedge clk);
    check("mid_pwm1_lft_active", bus_if.PWM1_lft, 1);
    check("mid_pwm2_rght_active", bus_if.PWM2_rght, 1);
    rst_n           = 1'b0;
    bus_if.lft_spd  = '0;
    bus_if.rght_spd = spd_t'(512);
    @(negedge clk);
    check("midrst_pwm_all", {bus_if.PWM1_lft, bus_if.PWM2_lft, bus_if.PWM1_rght,
                             bus_if.PWM2_rght}, 0);
    check("midrst_synch", bus_if.PWM_synch, 0);
    @(negedge clk);
    release_reset("rst2");

    run_period(-1, 0, 0, -1, -2, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("r2_pwm1_lft", h1l, 992);
    check("r2_pwm1_rght", h1r, 1504);

`ifdef OVR_I_SHTDWN_EN
    // ovr_i only inside blanking (through 40 clocks after rise) or while high sides are off
    sd_tot = 0;
    for (int p = 0; p < 9; p++) begin
      run_period(-1, 0, 0, 30, 73, 1600, 2000, h1l, h2l, h1r, h2r, ovl, syn, sd);
      sd_tot += sd;
    end
    check("blank_no_shtdwn", sd_tot, 0);
    check("blank_pwm1_lft", h1l, 992);
    check("blank_pwm2_rght", h2r, 480);

    // ovr_i held: shutdown at the 8th PWM_synch
    sd_tot = 0;
    for (int p = 0; p < 8; p++) begin
      run_period(-1, 0, 0, 0, 2047, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
      sd_tot += sd;
    end
    check("held_pre_shtdwn", sd_tot, 0);
    check("held_8th_synch", bus_if.PWM_synch, 1);
    check("held_shtdwn_at_synch", bus_if.ovr_i_shtdwn, 1);
    run_period(-1, 0, 0, 0, 2047, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
    check("shtdwn_pwm_off", h1l + h2l + h1r + h2r, 0);
    check("shtdwn_sticky", sd, 2048);
    check("shtdwn_cnt_runs", syn, 1);
`else
    sd_tot = 0;
    for (int p = 0; p < 20; p++) begin
      run_period(-1, 0, 0, 0, 2047, -1, -2, h1l, h2l, h1r, h2r, ovl, syn, sd);
      sd_tot += sd;
    end
    check("nomacro_shtdwn", sd_tot, 0);
    check("nomacro_pwm1_lft", h1l, 992);
    check("nomacro_pwm2_lft", h2l, 992);
    check("nomacro_pwm1_rght", h1r, 1504);
    check("nomacro_pwm2_rght", h2r, 480);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
